// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the IF/ID/EX pipeline controller.
// Revision: 1.0
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic [4:0] RV32I_REG_ZERO = 5'd0;

  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_HALT = 1'b1
  } pipe_state_e;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the EX load and the ID sources.
// Revision: 1.0
`default_nettype none

module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_valid_i,
  input  logic       ex_is_load_i,
  input  logic [4:0] ex_rd_i,
  input  logic       if_id_v_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  output logic       load_use_stall_o
);

  logic src_hit;

  // x0 never carries a real dependency, so a load to x0 must not stall.
  assign src_hit = (id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                   (id_rs2_used_i && (id_rs2_i == ex_rd_i));

  assign load_use_stall_o = ex_valid_i && ex_is_load_i && (ex_rd_i != RV32I_REG_ZERO) &&
                            if_id_v_i && src_hit;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: IF -> ID -> EX sequencer with load-use, busy-hold, redirect and EBREAK halt/resume.
// Revision: 1.0
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_is_load_i,
  input  logic             ex_busy_i,
  input  logic             ex_redirect_i,
  input  logic [XLEN-1:0]  ex_target_i,
  input  logic             ex_halt_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic             resume_i,
  output logic             pc_en_o,
  output logic             pc_redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_valid_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  pipe_state_e      state_q, state_d;
  logic             if_id_v_q, if_id_v_d;
  logic             id_ex_v_q, id_ex_v_d;
  logic [XLEN-1:0]  halt_pc_q, halt_pc_d;
  logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q;
  logic             load_use;

  assign ex_valid_o  = id_ex_v_q && (state_q == PC_RUN) && !rst;
  assign cycle_cnt_o = cycle_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

  hazard_detect u_hazard_detect (
    .ex_valid_i       (ex_valid_o),
    .ex_is_load_i     (ex_is_load_i),
    .ex_rd_i          (ex_rd_i),
    .if_id_v_i        (if_id_v_q),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_rs1_used_i    (id_rs1_used_i),
    .id_rs2_used_i    (id_rs2_used_i),
    .load_use_stall_o (load_use)
  );

  always_comb begin
    state_d       = state_q;
    halt_pc_d     = halt_pc_q;
    pc_en_o       = 1'b0;
    pc_redirect_o = 1'b0;
    redirect_pc_o = '0;
    if_id_en_o    = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_en_o    = 1'b0;
    id_ex_flush_o = 1'b0;
    halted_o      = 1'b0;

    if (rst) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      unique case (state_q)
        PC_RUN: begin
          if (ex_valid_o && ex_busy_i) begin
            // Hold everything; the EX instruction's side effects wait for completion.
          end else if (ex_valid_o && ex_halt_i) begin
            state_d       = PC_HALT;
            halt_pc_d     = ex_pc_i;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (ex_valid_o && ex_redirect_i) begin
            pc_en_o       = 1'b1;
            pc_redirect_o = 1'b1;
            redirect_pc_o = ex_target_i;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
          end else if (load_use) begin
            id_ex_flush_o = 1'b1;
          end else begin
            pc_en_o    = if_valid_i || !if_id_v_q;
            if_id_en_o = 1'b1;
            id_ex_en_o = 1'b1;
          end
        end
        PC_HALT: begin
          halted_o = 1'b1;
          // The PC must load the resume address, so it is enabled on the resume cycle.
          if (resume_i) begin
            pc_en_o       = 1'b1;
            pc_redirect_o = 1'b1;
            redirect_pc_o = halt_pc_q + XLEN'(4);
            state_d       = PC_RUN;
          end
        end
        default: state_d = PC_RUN;
      endcase
    end

    if_id_v_d = if_id_flush_o ? 1'b0 : (if_id_en_o ? if_valid_i : if_id_v_q);
    id_ex_v_d = id_ex_flush_o ? 1'b0 : (id_ex_en_o ? if_id_v_q : id_ex_v_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PC_RUN;
      if_id_v_q   <= 1'b0;
      id_ex_v_q   <= 1'b0;
      halt_pc_q   <= '0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      if_id_v_q <= if_id_v_d;
      id_ex_v_q <= id_ex_v_d;
      halt_pc_q <= halt_pc_d;
      if (state_q == PC_RUN) begin
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
        if (!pc_en_o) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
